// File: rtl/traffic_light_controller_pkg.sv
// Shared types and timing defaults for the single-road traffic-light sequencer.
package traffic_light_controller_pkg;

  // {Qa,Qb} encoding; 2'b11 is unused and treated as illegal.
  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } light_state_t;

  localparam int GREEN_MIN_DEF     = 1;
  localparam int YELLOW_CYCLES_DEF = 1;

  // Dwell counter must reach the larger of the two timing thresholds.
  function automatic int dwell_width(input int green_min, input int yellow_cycles);
    int m;
    m = (green_min > yellow_cycles) ? green_min : yellow_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/light_dwell_timer.sv
// Clearable saturating dwell counter with green-minimum and yellow-end terminal compares.
module light_dwell_timer
  import traffic_light_controller_pkg::*;
#(
  parameter int GREEN_MIN     = GREEN_MIN_DEF,
  parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic green_done,
  output logic yellow_done
);

  localparam int CW = dwell_width(GREEN_MIN, YELLOW_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Compared as signed ints so a threshold of zero stays a plain compare.
  always_comb begin
    green_done  = (int'(cnt) >= GREEN_MIN - 1);
    yellow_done = (int'(cnt) == YELLOW_CYCLES - 1);
  end

endmodule

// File: rtl/traffic_light_controller.sv
// RED/GREEN/YELLOW Moore sequencer: B requests go, A requests stop, dwell timer gates exits.
module traffic_light_controller
  import traffic_light_controller_pkg::*;
#(
  parameter int GREEN_MIN     = GREEN_MIN_DEF,
  parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RES1,
  input  logic RES2,
  input  logic A,
  input  logic B,
  output logic Qa,
  output logic Qb,
  output logic red,
  output logic green,
  output logic yellow
);

  light_state_t state;
  logic         rst;
  logic         leave;
  logic         green_done;
  logic         yellow_done;

  assign rst = RES1 | RES2;

  // leave also drives the timer clear, so the count restarts on every state change.
  always_comb begin
    leave = 1'b0;
    case (state)
      ST_RED:    leave = B;
      ST_GREEN:  leave = A & green_done;
      ST_YELLOW: leave = yellow_done;
      default:   leave = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= ST_RED;
    end else if (leave) begin
      case (state)
        ST_RED:   state <= ST_GREEN;
        ST_GREEN: state <= ST_YELLOW;
        default:  state <= ST_RED;
      endcase
    end
  end

  light_dwell_timer #(
    .GREEN_MIN     (GREEN_MIN),
    .YELLOW_CYCLES (YELLOW_CYCLES)
  ) u_timer (
    .clk         (CLK),
    .rst         (rst),
    .clr         (leave),
    .green_done  (green_done),
    .yellow_done (yellow_done)
  );

  assign Qa     = state[1];
  assign Qb     = state[0];
  assign red    = ~Qa & ~Qb;
  assign green  = ~Qa &  Qb;
  assign yellow =  Qa & ~Qb;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: default and (3,2)-timed instances against a phase/time model.
module tb_traffic_light_controller;

  logic CLK  = 1'b0;
  logic RES1 = 1'b1;
  logic RES2 = 1'b0;
  logic A    = 1'b0;
  logic B    = 1'b0;

  logic qa_d, qb_d, red_d, green_d, yellow_d;
  logic qa_t, qb_t, red_t, green_t, yellow_t;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=red 1=green 2=yellow, plus cycles already spent in that phase.
  int ph_d = 0, tm_d = 0;
  int ph_t = 0, tm_t = 0;
  bit model_ok = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  traffic_light_controller u_dut_d (
    .CLK(CLK), .RES1(RES1), .RES2(RES2), .A(A), .B(B),
    .Qa(qa_d), .Qb(qb_d), .red(red_d), .green(green_d), .yellow(yellow_d)
  );

  traffic_light_controller #(.GREEN_MIN(3), .YELLOW_CYCLES(2)) u_dut_t (
    .CLK(CLK), .RES1(RES1), .RES2(RES2), .A(A), .B(B),
    .Qa(qa_t), .Qb(qb_t), .red(red_t), .green(green_t), .yellow(yellow_t)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic model_step(inout int ph, inout int tm, input int gmin, input int ycyc,
                            input logic a, input logic b, input logic rst);
    if (rst) begin
      ph = 0; tm = 0;
    end else if (ph == 0 && b) begin
      ph = 1; tm = 0;
    end else if (ph == 1 && a && tm + 1 >= gmin) begin
      ph = 2; tm = 0;
    end else if (ph == 2 && tm + 1 == ycyc) begin
      ph = 0; tm = 0;
    end else begin
      tm++;
    end
  endtask

  function automatic logic [1:0] code_of(input int ph);
    return (ph == 1) ? 2'b01 : (ph == 2) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [2:0] lamps_of(input int ph);
    return (ph == 1) ? 3'b010 : (ph == 2) ? 3'b001 : 3'b100;
  endfunction

  // Advance the model on each edge, compare every output 1 time unit later.
  always @(posedge CLK) begin
    model_step(ph_d, tm_d, 1, 1, A, B, RES1 | RES2);
    model_step(ph_t, tm_t, 3, 2, A, B, RES1 | RES2);
    if (RES1 | RES2) model_ok = 1'b1;
    #1;
    if (model_ok) begin
      check("state_def",  {2'b00, qa_d, qb_d}, {2'b00, code_of(ph_d)});
      check("lamps_def",  {1'b0, red_d, green_d, yellow_d}, {1'b0, lamps_of(ph_d)});
      check("state_tmd",  {2'b00, qa_t, qb_t}, {2'b00, code_of(ph_t)});
      check("lamps_tmd",  {1'b0, red_t, green_t, yellow_t}, {1'b0, lamps_of(ph_t)});
    end
  end

  // ---------------- driver ----------------
  // Applies inputs for one edge, then pins both instances to hand-computed state codes.
  task automatic cyc(input logic [7:0] s);
    A = s[7]; B = s[6]; RES1 = s[5]; RES2 = s[4];
    @(posedge CLK);
    #2;
    check("lit_def", {2'b00, qa_d, qb_d}, {2'b00, s[3:2]});
    check("lit_tmd", {2'b00, qa_t, qb_t}, {2'b00, s[1:0]});
  endtask

  // {A, B, RES1, RES2, expected default {Qa,Qb}, expected timed {Qa,Qb}}
  logic [7:0] tbl [30] = '{
    8'b0010_0000, 8'b0001_0000,                                        // RES1, RES2
    8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, // idle
    8'b1000_0000,                                                      // A in red ignored
    8'b0100_0101, 8'b1000_1001, 8'b1000_0001, 8'b1000_0010,            // full cycle
    8'b0000_0010, 8'b0000_0000,                                        // timed yellow = 2
    8'b0100_0101, 8'b0000_0101, 8'b0000_0101, 8'b1001_0000,            // reset mid-green
    8'b0100_0101, 8'b1000_1001, 8'b1000_0001, 8'b1000_0010,            // full GREEN_MIN again
    8'b0001_0000,                                                      // reset mid-yellow
    8'b1100_0101, 8'b1100_1001, 8'b1100_0001, 8'b1100_0110,            // A=B=1
    8'b1100_1010, 8'b1100_0000, 8'b0000_0000
  };

  initial begin
    @(posedge CLK);
    #2;
    for (int i = 0; i < 30; i++) cyc(tbl[i]);

    for (int i = 0; i < 3000; i++) begin
      A    = 1'($urandom_range(0, 1));
      B    = 1'($urandom_range(0, 1));
      RES1 = ($urandom_range(0, 63) == 0);
      RES2 = ($urandom_range(0, 63) == 0);
      @(posedge CLK);
      #2;
    end
    A = 1'b0; B = 1'b0; RES1 = 1'b0; RES2 = 1'b0;
    repeat (3) @(posedge CLK);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
